cu_execution_controller: RTL and testbench
==========================================

Name: cu_execution_controller

Overview:
- Operator-side driver of the CU run-control interface. Generates the CPU start level, the step-execution mode level and the next-instruction stimulus that the microprogram sequencer consumes.
- Debounces raw board inputs (start button, step button, step-mode switch).
- Closes the step handshake by watching the published control address.
- Counts retired instructions for the front-panel display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a synchronized input level is accepted (10 ms at 100 MHz).
- COUNT_W, 16, width of the instruction counter.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous active-high reset
- i_start_btn  input  1  raw start/stop push button, asynchronous
- i_step_btn  input  1  raw next-instruction push button, asynchronous
- i_step_mode_sw  input  1  raw switch: 1 = step-by-step, 0 = auto run
- i_car_data  input  7  control address currently published by the sequencer
- i_ctrl_halt  input  1  HALT control bit (C23) from the current control word
- o_cpu_start  output  1  CPU start level to sequencer
- o_step_execution  output  1  step mode level to sequencer
- o_next_instr_stimulus  output  1  step request, held until acknowledged
- o_state  output  3  FSM state encoding for debug LEDs
- o_instr_count  output  COUNT_W  instructions fetched since start

Behaviour:
- Reset: single clock domain, i_clk. When i_rst=1 at a clock edge:
  - all outputs go to 0; state goes to IDLE;
  - debounce counters and synchronizers clear; debounced levels become 0.
- Input conditioning: each raw input passes a 2-flop synchronizer, then a stable counter.
  - The debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples.
  - A rising-edge pulse is asserted for exactly 1 cycle, in the cycle the debounced level goes 0->1.
- FSM states: IDLE=0, RUN=1, STEP_WAIT=2, STEP_REQ=3, HALTED=4. All outputs are registered; each reacts 1 cycle after its cause.
- IDLE: o_cpu_start=0.
  - On start pulse: latch o_step_execution <= debounced switch, clear o_instr_count, set o_cpu_start=1.
  - Go to RUN if the switch is 0, STEP_WAIT if it is 1.
- RUN: o_cpu_start=1, o_step_execution=0.
  - If the switch is 1 and i_car_data==FETCH_ADDR: set o_step_execution=1 and go to STEP_WAIT. The mode change takes effect only at a fetch boundary.
- STEP_WAIT: o_step_execution=1. The sequencer parks at NOP_WB_ADDR.
  - On step pulse: set o_next_instr_stimulus=1 and go to STEP_REQ.
  - If the switch is 0: clear o_step_execution and go to RUN.
  - Step pulses in any other state are discarded (not queued).
- STEP_REQ: hold o_next_instr_stimulus=1 until i_car_data transitions to FETCH_ADDR. Then deassert it in the next cycle and return to STEP_WAIT. Exactly one instruction executes per press.
- Halt: in RUN or STEP_WAIT, i_ctrl_halt=1 sends the FSM to HALTED.
  - o_cpu_start stays 1 so the sequencer holds its address.
  - o_next_instr_stimulus is forced to 0.
- Start pulse while in RUN, STEP_WAIT, STEP_REQ or HALTED: go to IDLE and clear o_cpu_start and o_next_instr_stimulus. o_instr_count keeps its value.
- Priority in a single cycle: i_rst > start pulse > halt > step/mode events.
- Instruction counter: increments when o_cpu_start=1 and i_car_data==FETCH_ADDR while the previous sample was not FETCH_ADDR. It wraps modulo 2^COUNT_W.
- Reset mid-handshake: the stimulus drops in the same cycle as reset; no pending request survives.

Optional Feature:
- Macro: CU_EXEC_BREAKPOINT_EN.
- Defined:
  - Adds input ports i_bp_en (1 bit) and i_bp_count (COUNT_W bits).
  - In RUN, when i_bp_en=1 and o_instr_count==i_bp_count at a fetch boundary, the FSM forces o_step_execution=1 and enters STEP_WAIT, regardless of the switch.
  - The forced step mode persists until the operator toggles the switch 1->0.
- Undefined: those ports do not exist; behaviour is exactly as above.

Decomposition:
- Package cu_exec_pkg holds:
  - the state enum (IDLE, RUN, STEP_WAIT, STEP_REQ, HALTED, 3-bit);
  - FETCH_ADDR = 7'h00 and NOP_WB_ADDR = 7'h20;
  - the default DEBOUNCE_CYCLES constant.
- Sub-module cu_debounce (synchronizer, stable counter, level output, rising-pulse output) is instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4 in simulation):
- Reset then start press with switch=0 -> o_cpu_start=1, o_step_execution=0, state=RUN. A CAR model cycling 0x00->0x0B->0x00 three times gives o_instr_count=3.
- Switch=1 and start press -> STEP_WAIT. Step press -> o_next_instr_stimulus rises, stays high while i_car_data=0x20, drops 1 cycle after i_car_data=0x00, and state returns to STEP_WAIT.
- Step button bouncing (pulses of 1-3 cycles) -> no stimulus. A level held for 4+ cycles -> exactly one stimulus.
- Switch 0->1 during RUN with i_car_data=0x0B -> o_step_execution stays 0 until i_car_data=0x00, then rises.
- i_ctrl_halt=1 in RUN -> state=HALTED, o_cpu_start stays 1, step presses ignored. A start press then gives state=IDLE, o_cpu_start=0.
- i_rst=1 during STEP_REQ -> all outputs 0 at the next edge, state=IDLE. With CU_EXEC_BREAKPOINT_EN defined and i_bp_count=2, auto run enters STEP_WAIT at the second fetch.

Source files
------------

// File: rtl/cu_exec_pkg.sv
// Shared types and constants for the CU run-control driver.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Contents: FSM state enum, sequencer fetch/park addresses, default debounce length.
package cu_exec_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    STEP_WAIT = 3'd2,
    STEP_REQ  = 3'd3,
    HALTED    = 3'd4
  } state_t;

  // Sequencer address of the instruction-fetch microroutine entry.
  localparam logic [6:0] FETCH_ADDR  = 7'h00;
  // Address where the sequencer parks while waiting for a step request.
  localparam logic [6:0] NOP_WB_ADDR = 7'h20;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

endpackage

// File: rtl/cu_debounce.sv
// Synchronizes and debounces one raw board input; emits the accepted level and a rise pulse.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable samples before o_level follows i_raw.
// Backpressure: none; o_rise is a single-cycle pulse with no handshake.
// Ports: i_clk, i_rst (sync, active high), i_raw (async) -> o_level, o_rise.
module cu_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync    <= 2'b00;
      cnt     <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
    end else begin
      sync   <= {sync[0], i_raw};
      o_rise <= 1'b0;
      if (sync[1] == o_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt     <= '0;
        o_level <= sync[1];
        o_rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cu_execution_controller.sv
// Operator-side run-control driver: start level, step mode and step stimulus for the sequencer.
// Latency: every output registered, reacting 1 cycle after its (debounced) cause.
// Backpressure: step request is held until the sequencer re-enters FETCH_ADDR.
// Ports: i_clk, i_rst, i_start_btn, i_step_btn, i_step_mode_sw, i_car_data[6:0], i_ctrl_halt
//        -> o_cpu_start, o_step_execution, o_next_instr_stimulus, o_state[2:0], o_instr_count.
// Option: define CU_EXEC_BREAKPOINT_EN to add i_bp_en/i_bp_count instruction-count breakpoints.
module cu_execution_controller
  import cu_exec_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start_btn,
  input  logic               i_step_btn,
  input  logic               i_step_mode_sw,
  input  logic [6:0]         i_car_data,
  input  logic               i_ctrl_halt,
`ifdef CU_EXEC_BREAKPOINT_EN
  input  logic               i_bp_en,
  input  logic [COUNT_W-1:0] i_bp_count,
`endif
  output logic               o_cpu_start,
  output logic               o_step_execution,
  output logic               o_next_instr_stimulus,
  output logic [2:0]         o_state,
  output logic [COUNT_W-1:0] o_instr_count
);

  logic start_lvl, start_p;
  logic step_lvl, step_p;
  logic mode_lvl, mode_rise;

  cu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_start_btn),
    .o_level(start_lvl), .o_rise(start_p)
  );
  cu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_step_btn),
    .o_level(step_lvl), .o_rise(step_p)
  );
  cu_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .i_clk(i_clk), .i_rst(i_rst), .i_raw(i_step_mode_sw),
    .o_level(mode_lvl), .o_rise(mode_rise)
  );

  // Buttons act on edges only and the switch on its level.
  logic unused_db;
  assign unused_db = start_lvl ^ step_lvl ^ mode_rise;

  state_t             state;
  logic               prev_fetch;
  logic               fetch_now, fetch_edge, cnt_inc;
  logic [COUNT_W-1:0] cnt_next;
  logic               enter_step;  // RUN -> STEP_WAIT request at a fetch boundary
  logic               hold_step;   // keep STEP_WAIT instead of resuming RUN

  assign fetch_now  = (i_car_data == FETCH_ADDR);
  assign fetch_edge = fetch_now && !prev_fetch;
  assign cnt_inc    = o_cpu_start && fetch_edge;
  assign cnt_next   = o_instr_count + COUNT_W'(cnt_inc);
  assign o_state    = state;

`ifdef CU_EXEC_BREAKPOINT_EN
  logic bp_hit, bp_force, mode_prev;

  // Compare against the post-increment count so the breakpoint lands on the
  // fetch that makes the count equal, even if FETCH_ADDR lasts one cycle.
  assign bp_hit     = i_bp_en && fetch_now && (cnt_next == i_bp_count);
  assign enter_step = fetch_now && (mode_lvl || bp_hit);
  assign hold_step  = mode_lvl || bp_force;

  // Forced step mode is released only by an operator 1->0 switch toggle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bp_force  <= 1'b0;
      mode_prev <= 1'b0;
    end else begin
      mode_prev <= mode_lvl;
      if (start_p)
        bp_force <= 1'b0;
      else if (state == RUN && !i_ctrl_halt && bp_hit)
        bp_force <= 1'b1;
      else if (mode_prev && !mode_lvl)
        bp_force <= 1'b0;
    end
  end
`else
  assign enter_step = fetch_now && mode_lvl;
  assign hold_step  = mode_lvl;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                 <= IDLE;
      o_cpu_start           <= 1'b0;
      o_step_execution      <= 1'b0;
      o_next_instr_stimulus <= 1'b0;
      o_instr_count         <= '0;
      prev_fetch            <= 1'b0;
    end else begin
      prev_fetch    <= fetch_now;
      o_instr_count <= cnt_next;
      if (state == IDLE) begin
        if (start_p) begin
          o_step_execution <= mode_lvl;
          o_instr_count    <= '0;
          o_cpu_start      <= 1'b1;
          state            <= mode_lvl ? STEP_WAIT : RUN;
        end
      end else if (start_p) begin
        // Stop request wins over everything else; the count is preserved.
        state                 <= IDLE;
        o_cpu_start           <= 1'b0;
        o_next_instr_stimulus <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (i_ctrl_halt) begin
              state <= HALTED;
            end else if (enter_step) begin
              o_step_execution <= 1'b1;
              state            <= STEP_WAIT;
            end
          end
          STEP_WAIT: begin
            if (i_ctrl_halt) begin
              o_next_instr_stimulus <= 1'b0;
              state                 <= HALTED;
            end else if (!hold_step) begin
              o_step_execution <= 1'b0;
              state            <= RUN;
            end else if (step_p) begin
              o_next_instr_stimulus <= 1'b1;
              state                 <= STEP_REQ;
            end
          end
          STEP_REQ: begin
            // Sequencer re-entering fetch acknowledges exactly one instruction.
            if (fetch_edge) begin
              o_next_instr_stimulus <= 1'b0;
              state                 <= STEP_WAIT;
            end
          end
          HALTED: begin
            o_next_instr_stimulus <= 1'b0;
          end
          default: begin
            o_cpu_start           <= 1'b0;
            o_next_instr_stimulus <= 1'b0;
            state                 <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cu_execution_controller.sv
// Directed/randomized bench for cu_execution_controller with a transaction-level expectation model.
// Latency: n/a.  Backpressure: n/a.
// Option: honours CU_EXEC_BREAKPOINT_EN to exercise the breakpoint ports.
module tb_cu_execution_controller;

  localparam int DB = 4;
  localparam int CW = 4;  // narrow counter so wrap-around is reachable

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_SWAIT = 3'd2,
                         S_SREQ = 3'd3, S_HALT = 3'd4;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start_btn, i_step_btn, i_step_mode_sw, i_ctrl_halt;
  logic [6:0]    i_car_data;
`ifdef CU_EXEC_BREAKPOINT_EN
  logic          i_bp_en;
  logic [CW-1:0] i_bp_count;
`endif
  logic          o_cpu_start, o_step_execution, o_next_instr_stimulus;
  logic [2:0]    o_state;
  logic [CW-1:0] o_instr_count;

  cu_execution_controller #(.DEBOUNCE_CYCLES(DB), .COUNT_W(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_start_btn(i_start_btn), .i_step_btn(i_step_btn), .i_step_mode_sw(i_step_mode_sw),
    .i_car_data(i_car_data), .i_ctrl_halt(i_ctrl_halt),
`ifdef CU_EXEC_BREAKPOINT_EN
    .i_bp_en(i_bp_en), .i_bp_count(i_bp_count),
`endif
    .o_cpu_start(o_cpu_start), .o_step_execution(o_step_execution),
    .o_next_instr_stimulus(o_next_instr_stimulus), .o_state(o_state),
    .o_instr_count(o_instr_count)
  );

  always #5 i_clk = ~i_clk;

  int            errors = 0;
  int            checks = 0;
  int            stim_rises = 0;
  logic          stim_q = 1'b0;
  logic [CW-1:0] exp_count = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_next_instr_stimulus === 1'b1 && stim_q === 1'b0) stim_rises++;
    stim_q = o_next_instr_stimulus;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int which, input int hold);
    if (which == 0) i_start_btn = 1'b1; else i_step_btn = 1'b1;
    repeat (hold) tick();
    if (which == 0) i_start_btn = 1'b0; else i_step_btn = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] exp, input int budget, input string tag);
    int n = 0;
    while (o_state !== exp && n < budget) begin tick(); n++; end
    check(tag, 32'(o_state), 32'(exp));
  endtask

  task automatic wait_stim(input int budget, input string tag);
    int n = 0;
    while (o_next_instr_stimulus !== 1'b1 && n < budget) begin tick(); n++; end
    check(tag, 32'(o_next_instr_stimulus), 32'd1);
  endtask

  // One operator step: press, see the request, park, then release it via fetch.
  task automatic do_step(input string tag);
    int   r0 = stim_rises;
    logic held = 1'b1;
    i_car_data = 7'h20;
    press(1, $urandom_range(DB, DB + 3));
    wait_stim(20, {tag, "_stim_up"});
    check({tag, "_state_req"}, 32'(o_state), 32'(S_SREQ));
    repeat ($urandom_range(1, 4)) begin
      tick();
      if (o_next_instr_stimulus !== 1'b1) held = 1'b0;
    end
    check({tag, "_stim_held"}, 32'(held), 32'd1);
    i_car_data = 7'h00;
    tick();
    exp_count++;
    check({tag, "_stim_drop"}, 32'(o_next_instr_stimulus), 32'd0);
    check({tag, "_state_back"}, 32'(o_state), 32'(S_SWAIT));
    i_car_data = 7'h20;
    settle(12);
    check({tag, "_one_req"}, 32'(stim_rises - r0), 32'd1);
  endtask

  initial begin
    int n_instr;
    int r0;
    logic seen;

    i_rst = 1'b1; i_start_btn = 1'b0; i_step_btn = 1'b0; i_step_mode_sw = 1'b0;
    i_ctrl_halt = 1'b0; i_car_data = 7'h00;
`ifdef CU_EXEC_BREAKPOINT_EN
    i_bp_en = 1'b0; i_bp_count = '0;
`endif
    settle(3);
    check("rst_state", 32'(o_state), 32'(S_IDLE));
    check("rst_start", 32'(o_cpu_start), 32'd0);
    check("rst_step",  32'(o_step_execution), 32'd0);
    check("rst_stim",  32'(o_next_instr_stimulus), 32'd0);
    check("rst_count", 32'(o_instr_count), 32'd0);
    i_rst = 1'b0;
    settle(2);

    // Auto run: a start press with the switch low, then a burst of fetches.
    press(0, $urandom_range(DB, DB + 3));
    wait_state(S_RUN, 20, "run_state");
    check("run_start", 32'(o_cpu_start), 32'd1);
    check("run_step",  32'(o_step_execution), 32'd0);
    exp_count = '0;
    n_instr = $urandom_range(3, 20);
    for (int i = 0; i < n_instr; i++) begin
      i_car_data = 7'($urandom_range(1, 127));
      repeat ($urandom_range(1, 3)) tick();
      i_car_data = 7'h00;
      repeat ($urandom_range(1, 2)) tick();
      exp_count++;
    end
    check("run_count", 32'(o_instr_count), 32'(exp_count));
    check("run_still", 32'(o_state), 32'(S_RUN));

    // Switch to step mode mid-instruction: must wait for the fetch boundary.
    i_car_data = 7'h0B;
    tick();
    i_step_mode_sw = 1'b1;
    settle(10);
    check("mode_wait_step", 32'(o_step_execution), 32'd0);
    check("mode_wait_state", 32'(o_state), 32'(S_RUN));
    i_car_data = 7'h00;
    tick();
    exp_count++;
    check("mode_fetch_step", 32'(o_step_execution), 32'd1);
    check("mode_fetch_state", 32'(o_state), 32'(S_SWAIT));
    i_car_data = 7'h20;
    tick();

    // Step handshake, a few presses.
    repeat ($urandom_range(2, 3)) do_step("step");
    check("step_count", 32'(o_instr_count), 32'(exp_count));

    // Bouncing step button must never produce a request.
    r0 = stim_rises;
    seen = 1'b0;
    repeat (6) begin
      i_step_btn = 1'b1;
      repeat ($urandom_range(1, DB - 1)) tick();
      i_step_btn = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
      if (o_next_instr_stimulus !== 1'b0) seen = 1'b1;
    end
    settle(10);
    check("bounce_none", 32'(stim_rises - r0), 32'd0);
    check("bounce_lvl", 32'(seen), 32'd0);
    do_step("held");

    // Back to auto run, then halt.
    i_step_mode_sw = 1'b0;
    wait_state(S_RUN, 15, "resume_state");
    check("resume_step", 32'(o_step_execution), 32'd0);
    i_car_data = 7'h0B;
    tick();
    i_ctrl_halt = 1'b1;
    tick();
    check("halt_state", 32'(o_state), 32'(S_HALT));
    check("halt_start", 32'(o_cpu_start), 32'd1);
    i_ctrl_halt = 1'b0;
    r0 = stim_rises;
    press(1, DB + 1);
    settle(10);
    check("halt_ignore_step", 32'(stim_rises - r0), 32'd0);
    check("halt_hold", 32'(o_state), 32'(S_HALT));
    press(0, DB + 1);
    wait_state(S_IDLE, 20, "stop_state");
    check("stop_start", 32'(o_cpu_start), 32'd0);
    check("stop_count_kept", 32'(o_instr_count), 32'(exp_count));

    // Start directly into step mode, then reset in the middle of a request.
    i_step_mode_sw = 1'b1;
    i_car_data = 7'h20;
    settle(8);
    press(0, DB);
    wait_state(S_SWAIT, 20, "sstart_state");
    check("sstart_step", 32'(o_step_execution), 32'd1);
    check("sstart_count", 32'(o_instr_count), 32'd0);
    press(1, DB + 2);
    wait_stim(20, "rreq_stim");
    check("rreq_state", 32'(o_state), 32'(S_SREQ));
    i_rst = 1'b1;
    tick();
    check("mrst_stim",  32'(o_next_instr_stimulus), 32'd0);
    check("mrst_start", 32'(o_cpu_start), 32'd0);
    check("mrst_step",  32'(o_step_execution), 32'd0);
    check("mrst_count", 32'(o_instr_count), 32'd0);
    check("mrst_state", 32'(o_state), 32'(S_IDLE));
    i_rst = 1'b0;
    r0 = stim_rises;
    i_car_data = 7'h00;
    tick();
    i_car_data = 7'h20;
    settle(10);
    check("mrst_no_pending", 32'(stim_rises - r0), 32'd0);
    check("mrst_idle", 32'(o_state), 32'(S_IDLE));

`ifdef CU_EXEC_BREAKPOINT_EN
    // Breakpoint forces step mode at the N-th fetch regardless of the switch.
    begin
      int bp_n;
      i_step_mode_sw = 1'b0;
      i_car_data = 7'h00;
      settle(10);
      bp_n = $urandom_range(2, 5);
      i_bp_en = 1'b1;
      i_bp_count = CW'(bp_n);
      press(0, DB);
      wait_state(S_RUN, 20, "bp_run");
      for (int i = 1; i <= bp_n; i++) begin
        i_car_data = 7'($urandom_range(1, 127));
        repeat ($urandom_range(1, 3)) tick();
        i_car_data = 7'h00;
        tick();
        check("bp_fetch_state", 32'(o_state), 32'((i == bp_n) ? S_SWAIT : S_RUN));
      end
      check("bp_step", 32'(o_step_execution), 32'd1);
      check("bp_count", 32'(o_instr_count), 32'(bp_n));
      i_car_data = 7'h20;
      settle(10);
      check("bp_forced", 32'(o_state), 32'(S_SWAIT));
      i_step_mode_sw = 1'b1;
      settle(10);
      i_step_mode_sw = 1'b0;
      wait_state(S_RUN, 20, "bp_release");
      check("bp_release_step", 32'(o_step_execution), 32'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
